// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider (unsigned).
// Computes one quotient bit per SHIFT/TEST pair, so a normal division
// takes 2*WIDTH+1 edges from the accepting edge to the done pulse.
// A zero divisor short-circuits from LOAD straight to DONE with a flag.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    TEST,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_sub;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // Restoring trial subtraction: keep the difference only if it does not underflow
  always_comb begin
    r_sub  = r - {1'b0, d};
    r_next = r;
    q_next = q;
    if (r >= {1'b0, d}) begin
      r_next = r_sub;
      q_next = {q[WIDTH-1:1], 1'b1};
    end
  end

  // Control FSM and datapath registers; outputs are all registered here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q           <= dividend;
            d           <= divisor;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          r   <= '0;
          cnt <= CW'(WIDTH);
          if (d == '0) begin
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= q;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          r     <= {r[WIDTH-1:0], q[WIDTH-1]};
          q     <= {q[WIDTH-2:0], 1'b0};
          cnt   <= cnt - CW'(1);
          state <= TEST;
        end
        TEST: begin
          r <= r_next;
          q <= q_next;
          if (cnt == '0) begin
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
